id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode stage + ID/EX pipeline register. Drives regfile read addresses from the IF/ID
//  instruction, decodes controls, generates RV32I immediates, detects load-use hazards
//  and registers all operands/controls for EX. Regfile writes on negedge, so no WB bypass here.
// PARAMETERS
//  XLEN       32             datapath width
//  NOP_INSTR  32'h0000_0013  instruction treated as bubble (ADDI x0,x0,0)
// PORTS
//  clk          in   1     rising-edge clock
//  reset_n      in   1     synchronous reset, active-low
//  instr_d      in   32    IF/ID instruction
//  pc_d         in   XLEN  IF/ID PC
//  valid_d      in   1     IF/ID slot holds a real instruction
//  rs1_addr     out  5     regfile read addr = instr_d[19:15] (comb)
//  rs2_addr     out  5     regfile read addr = instr_d[24:20] (comb)
//  rs1_data     in   XLEN  regfile read data (comb, x0 reads 0)
//  rs2_data     in   XLEN  regfile read data
//  flush_e      in   1     branch/jump taken in EX: kill D instruction
//  hold_e       in   1     downstream busy: freeze ID/EX
//  stall_fd     out  1     freeze PC and IF/ID (comb)
//  valid_e      out  1     EX slot valid
//  pc_e, rs1_data_e, rs2_data_e, imm_e  out XLEN  registered operands
//  rs1_e, rs2_e, rd_e  out 5   registered register indices (for EX forwarding)
//  funct3_e     out  3;  funct7b5_e out 1;  opcode_e out 7
//  reg_we_e, mem_read_e, mem_write_e, branch_e, jump_e, illegal_e  out 1 each
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): all _e outputs 0, valid_e=0; stall_fd=0 that cycle.
//  Latency: one cycle D->E. Next-state priority each posedge:
//   1 reset  2 flush_e: bubble  3 hold_e: keep all _e regs  4 load_use: bubble  5 load D.
//  Bubble = valid_e=0, reg_we_e=mem_read_e=mem_write_e=branch_e=jump_e=illegal_e=0, rd_e=0.
//  load_use (comb) = valid_e & mem_read_e & rd_e!=0 & valid_d &
//    ((uses_rs1 & rd_e==instr_d[19:15]) | (uses_rs2 & rd_e==instr_d[24:20])).
//  uses_rs1: R,I-ALU,LOAD,STORE,BRANCH,JALR. uses_rs2: R,STORE,BRANCH. LUI/AUIPC/JAL none.
//  stall_fd = ~flush_e & (hold_e | load_use). flush_e suppresses stall_fd.
//  Load-use inserts exactly one bubble; next cycle mem_read_e=0 so D proceeds.
//  valid_d=0 or instr_d==NOP_INSTR: loaded as bubble (valid_e=0).
//  Decode (opcode=instr[6:0]): R 0110011 we; I 0010011 we; LOAD 0000011 we,mem_read;
//   STORE 0100011 mem_write; BRANCH 1100011 branch; JAL 1101111 we,jump;
//   JALR 1100111 we,jump; LUI 0110111 we; AUIPC 0010111 we.
//   Other opcode: valid_e=1, illegal_e=1, all other ctrl 0.
//  reg_we_e forced 0 when rd==0. funct7b5_e=instr[30].
//  Immediates sign-extended from instr[31] to XLEN:
//   I {instr[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0};
//   U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; R imm_e=0.
//  Reset mid-stall: reset wins, stall_fd=0 after reset edge.
// TESTING
//  reset_n=0 2 cycles, instr_d=ADD -> valid_e=0, all ctrl 0, stall_fd=0.
//  instr_d=32'hFFF00093 (addi x1,x0,-1), pc_d=0x40 -> next cycle imm_e=0xFFFFFFFF,
//   rd_e=1, reg_we_e=1, pc_e=0x40, stall_fd=0.
//  lw x5,0(x2) then add x6,x5,x7 -> stall_fd=1 one cycle, one bubble, then add in EX
//   with rs1_e=5; same with rd=x0 (lw x0) -> no stall.
//  load-use condition plus flush_e=1 same cycle -> stall_fd=0, valid_e=0 next cycle.
//  hold_e=1 for 3 cycles -> _e regs unchanged, stall_fd=1; release -> D loads.
//  beq with instr 32'hFE000EE3 -> branch_e=1, imm_e=0xFFFFFFFC; opcode 7'h7F -> illegal_e=1.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: IF/ID inputs, regfile read port, hazard controls and ID/EX outputs of the decode stage.
interface id_ex_stage_if #(parameter int XLEN = 32);
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_d;
    logic            valid_d;
    logic [4:0]      rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            flush_e, hold_e, stall_fd, valid_e;
    logic [XLEN-1:0] pc_e, rs1_data_e, rs2_data_e, imm_e;
    logic [4:0]      rs1_e, rs2_e, rd_e;
    logic [2:0]      funct3_e;
    logic            funct7b5_e;
    logic [6:0]      opcode_e;
    logic            reg_we_e, mem_read_e, mem_write_e, branch_e, jump_e, illegal_e;
    modport slave (
        input  instr_d, pc_d, valid_d, rs1_data, rs2_data, flush_e, hold_e,
        output rs1_addr, rs2_addr, stall_fd, valid_e, pc_e, rs1_data_e, rs2_data_e, imm_e,
               rs1_e, rs2_e, rd_e, funct3_e, funct7b5_e, opcode_e,
               reg_we_e, mem_read_e, mem_write_e, branch_e, jump_e, illegal_e
    );
    modport master (
        output instr_d, pc_d, valid_d, rs1_data, rs2_data, flush_e, hold_e,
        input  rs1_addr, rs2_addr, stall_fd, valid_e, pc_e, rs1_data_e, rs2_data_e, imm_e,
               rs1_e, rs2_e, rd_e, funct3_e, funct7b5_e, opcode_e,
               reg_we_e, mem_read_e, mem_write_e, branch_e, jump_e, illegal_e
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode, immediate generation, load-use detection and ID/EX register.
module id_ex_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           clk,
    input logic           reset_n,
    id_ex_stage_if.slave  bus
);
    logic [31:0]     in;
    logic [6:0]      op;
    logic            is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic            legal, uses_rs1, uses_rs2, live, load_use, kill;
    logic [XLEN-1:0] imm;
    assign in       = bus.instr_d;
    assign op       = in[6:0];
    assign is_r     = op == 7'b0110011;
    assign is_i     = op == 7'b0010011;
    assign is_ld    = op == 7'b0000011;
    assign is_st    = op == 7'b0100011;
    assign is_br    = op == 7'b1100011;
    assign is_jal   = op == 7'b1101111;
    assign is_jalr  = op == 7'b1100111;
    assign is_lui   = op == 7'b0110111;
    assign is_auipc = op == 7'b0010111;
    assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
    assign uses_rs1 = is_r | is_i | is_ld | is_st | is_br | is_jalr;
    assign uses_rs2 = is_r | is_st | is_br;
    assign live     = bus.valid_d && in != NOP_INSTR;
    assign bus.rs1_addr = in[19:15];
    assign bus.rs2_addr = in[24:20];
    assign load_use = bus.valid_e & bus.mem_read_e & (bus.rd_e != 5'd0) & bus.valid_d &
                      ((uses_rs1 & (bus.rd_e == in[19:15])) | (uses_rs2 & (bus.rd_e == in[24:20])));
    assign bus.stall_fd = reset_n & ~bus.flush_e & (bus.hold_e | load_use);
    // Anything that must not reach EX as a live instruction becomes a bubble.
    assign kill = bus.flush_e | load_use | ~live;
    assign imm = (is_i | is_ld | is_jalr) ? {{(XLEN-12){in[31]}}, in[31:20]} :
                 is_st                    ? {{(XLEN-12){in[31]}}, in[31:25], in[11:7]} :
                 is_br                    ? {{(XLEN-12){in[31]}}, in[7], in[30:25], in[11:8], 1'b0} :
                 (is_lui | is_auipc)      ? {{(XLEN-31){in[31]}}, in[30:12], 12'b0} :
                 is_jal                   ? {{(XLEN-20){in[31]}}, in[19:12], in[20], in[30:21], 1'b0} :
                                            '0;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.valid_e     <= 1'b0;
            bus.pc_e        <= '0;
            bus.rs1_data_e  <= '0;
            bus.rs2_data_e  <= '0;
            bus.imm_e       <= '0;
            bus.rs1_e       <= '0;
            bus.rs2_e       <= '0;
            bus.rd_e        <= '0;
            bus.funct3_e    <= '0;
            bus.funct7b5_e  <= 1'b0;
            bus.opcode_e    <= '0;
            bus.reg_we_e    <= 1'b0;
            bus.mem_read_e  <= 1'b0;
            bus.mem_write_e <= 1'b0;
            bus.branch_e    <= 1'b0;
            bus.jump_e      <= 1'b0;
            bus.illegal_e   <= 1'b0;
        end else if (bus.flush_e || !bus.hold_e) begin
            bus.valid_e     <= !kill;
            bus.pc_e        <= bus.pc_d;
            bus.rs1_data_e  <= bus.rs1_data;
            bus.rs2_data_e  <= bus.rs2_data;
            bus.imm_e       <= imm;
            bus.rs1_e       <= in[19:15];
            bus.rs2_e       <= in[24:20];
            bus.rd_e        <= kill ? 5'd0 : in[11:7];
            bus.funct3_e    <= in[14:12];
            bus.funct7b5_e  <= in[30];
            bus.opcode_e    <= op;
            bus.reg_we_e    <= !kill & legal & !(is_st | is_br) & (in[11:7] != 5'd0);
            bus.mem_read_e  <= !kill & is_ld;
            bus.mem_write_e <= !kill & is_st;
            bus.branch_e    <= !kill & is_br;
            bus.jump_e      <= !kill & (is_jal | is_jalr);
            bus.illegal_e   <= !kill & !legal;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed decode/hazard vectors against hand-computed ID/EX results.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   errs = 0;
    localparam logic [31:0] ADD   = 32'h0072_8333;
    localparam logic [31:0] ADDX0 = 32'h0070_0333;
    localparam logic [31:0] ADDI  = 32'hFFF0_0093;
    localparam logic [31:0] LW5   = 32'h0001_2283;
    localparam logic [31:0] LW0   = 32'h0001_2003;
    localparam logic [31:0] BEQ   = 32'hFE00_0EE3;
    localparam logic [31:0] SW    = 32'hFE71_2E23;
    localparam logic [31:0] JAL   = 32'h0080_00EF;
    localparam logic [31:0] LUI   = 32'h1234_51B7;
    localparam logic [31:0] BAD   = 32'h0000_007F;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    id_ex_stage_if #(.XLEN(32)) bus ();
    id_ex_stage #(.XLEN(32), .NOP_INSTR(NOP)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;
    // Regfile stand-in: xN reads 0x1000_0000+N, x0 reads 0.
    assign bus.rs1_data = (bus.rs1_addr == 5'd0) ? 32'd0 : 32'h1000_0000 + 32'(bus.rs1_addr);
    assign bus.rs2_data = (bus.rs2_addr == 5'd0) ? 32'd0 : 32'h1000_0000 + 32'(bus.rs2_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] pc);
        bus.instr_d = i;
        bus.pc_d    = pc;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; bus.valid_d = 1'b1; bus.flush_e = 1'b0; bus.hold_e = 1'b0;
        drive(ADD, 32'h0);
        tick(); tick();
        chk("rst_valid", 32'(bus.valid_e), 0);
        chk("rst_we", 32'(bus.reg_we_e), 0);
        chk("rst_mr", 32'(bus.mem_read_e), 0);
        chk("rst_rd", 32'(bus.rd_e), 0);
        chk("rst_imm", bus.imm_e, 0);
        chk("rst_stall", 32'(bus.stall_fd), 0);
        reset_n = 1'b1;
        drive(ADDI, 32'h40);
        chk("addi_stall", 32'(bus.stall_fd), 0);
        chk("rs1_addr", 32'(bus.rs1_addr), 0);
        tick();
        chk("addi_imm", bus.imm_e, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(bus.rd_e), 1);
        chk("addi_we", 32'(bus.reg_we_e), 1);
        chk("addi_pc", bus.pc_e, 32'h40);
        chk("addi_valid", 32'(bus.valid_e), 1);
        chk("addi_op", 32'(bus.opcode_e), 32'h13);
        drive(LW5, 32'h44);
        tick();
        chk("lw_mr", 32'(bus.mem_read_e), 1);
        chk("lw_rd", 32'(bus.rd_e), 5);
        chk("lw_f3", 32'(bus.funct3_e), 2);
        drive(ADD, 32'h48);
        chk("lu_stall", 32'(bus.stall_fd), 1);
        tick();
        chk("lu_bub_valid", 32'(bus.valid_e), 0);
        chk("lu_bub_mr", 32'(bus.mem_read_e), 0);
        chk("lu_bub_rd", 32'(bus.rd_e), 0);
        chk("lu_stall_clr", 32'(bus.stall_fd), 0);
        tick();
        chk("add_valid", 32'(bus.valid_e), 1);
        chk("add_rs1", 32'(bus.rs1_e), 5);
        chk("add_rs2", 32'(bus.rs2_e), 7);
        chk("add_rd", 32'(bus.rd_e), 6);
        chk("add_d1", bus.rs1_data_e, 32'h1000_0005);
        chk("add_d2", bus.rs2_data_e, 32'h1000_0007);
        chk("add_pc", bus.pc_e, 32'h48);
        chk("add_imm", bus.imm_e, 0);
        drive(LW0, 32'h4C);
        tick();
        chk("lw0_mr", 32'(bus.mem_read_e), 1);
        chk("lw0_we", 32'(bus.reg_we_e), 0);
        drive(ADDX0, 32'h50);
        chk("lw0_nostall", 32'(bus.stall_fd), 0);
        tick();
        chk("addx0_valid", 32'(bus.valid_e), 1);
        drive(LW5, 32'h54);
        tick();
        bus.flush_e = 1'b1;
        drive(ADD, 32'h58);
        chk("flush_stall", 32'(bus.stall_fd), 0);
        tick();
        chk("flush_valid", 32'(bus.valid_e), 0);
        chk("flush_we", 32'(bus.reg_we_e), 0);
        bus.flush_e = 1'b0;
        drive(ADDI, 32'h60);
        tick();
        bus.hold_e = 1'b1;
        drive(ADD, 32'h64);
        for (int k = 0; k < 3; k++) begin
            chk("hold_stall", 32'(bus.stall_fd), 1);
            tick();
            chk("hold_rd", 32'(bus.rd_e), 1);
            chk("hold_imm", bus.imm_e, 32'hFFFF_FFFF);
            chk("hold_pc", bus.pc_e, 32'h60);
        end
        bus.hold_e = 1'b0;
        #1;
        chk("rel_stall", 32'(bus.stall_fd), 0);
        tick();
        chk("rel_rd", 32'(bus.rd_e), 6);
        chk("rel_pc", bus.pc_e, 32'h64);
        drive(BEQ, 32'h68);
        tick();
        chk("beq_br", 32'(bus.branch_e), 1);
        chk("beq_imm", bus.imm_e, 32'hFFFF_FFFC);
        chk("beq_we", 32'(bus.reg_we_e), 0);
        drive(SW, 32'h6C);
        tick();
        chk("sw_mw", 32'(bus.mem_write_e), 1);
        chk("sw_imm", bus.imm_e, 32'hFFFF_FFFC);
        chk("sw_we", 32'(bus.reg_we_e), 0);
        drive(JAL, 32'h70);
        tick();
        chk("jal_j", 32'(bus.jump_e), 1);
        chk("jal_imm", bus.imm_e, 32'h8);
        chk("jal_we", 32'(bus.reg_we_e), 1);
        drive(LUI, 32'h74);
        tick();
        chk("lui_imm", bus.imm_e, 32'h1234_5000);
        chk("lui_rd", 32'(bus.rd_e), 3);
        drive(BAD, 32'h78);
        tick();
        chk("ill_ill", 32'(bus.illegal_e), 1);
        chk("ill_valid", 32'(bus.valid_e), 1);
        chk("ill_we", 32'(bus.reg_we_e), 0);
        bus.valid_d = 1'b0;
        drive(ADDI, 32'h7C);
        tick();
        chk("vd0_valid", 32'(bus.valid_e), 0);
        chk("vd0_we", 32'(bus.reg_we_e), 0);
        bus.valid_d = 1'b1;
        drive(NOP, 32'h80);
        tick();
        chk("nop_valid", 32'(bus.valid_e), 0);
        drive(LW5, 32'h84);
        tick();
        drive(ADD, 32'h88);
        chk("mid_stall", 32'(bus.stall_fd), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(bus.stall_fd), 0);
        chk("mid_rst_valid", 32'(bus.valid_e), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
